// File: rtl/rib_arbiter_pkg.sv
// rib_arbiter_pkg: shared state encodings and defaults for the rib bus arbiter
package rib_arbiter_pkg;
  localparam logic [0:0] RIB_IDLE = 1'b0;
  localparam logic [0:0] RIB_BUSY = 1'b1;
  localparam int RIB_TIMEOUT_DEFAULT = 16;
  localparam int RIB_MAX_MASTERS = 8;
  function automatic int rib_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction
endpackage

// File: rtl/rib_arbiter_if.sv
// rib_arbiter_if: master-side and slave-side rib bus signals seen by the arbiter
interface rib_arbiter_if #(
  parameter int NUM_M = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_M-1:0] m_req_i;
  logic [NUM_M-1:0] m_we_i;
  logic [NUM_M*ADDR_W-1:0] m_addr_i;
  logic [NUM_M*DATA_W-1:0] m_wdata_i;
  logic [NUM_M-1:0] m_ack_o;
  logic [NUM_M-1:0] m_err_o;
  logic [DATA_W-1:0] m_rdata_o;
  logic [NUM_M-1:0] grant_o;
  logic s_req_o;
  logic s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_wdata_o;
  logic s_ack_i;
  logic [DATA_W-1:0] s_rdata_i;
  logic hold_flag_o;
  modport slave (
    input m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    output m_ack_o, m_err_o, m_rdata_o, grant_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, hold_flag_o
  );
  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    input m_ack_o, m_err_o, m_rdata_o, grant_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, hold_flag_o
  );
endinterface

// File: rtl/rib_arbiter_prio_enc.sv
// rib_prio_enc: one-hot select of the lowest-index active request
module rib_prio_enc #(
  parameter int NUM_M = 3
) (
  input  logic [NUM_M-1:0] req,
  output logic [NUM_M-1:0] gnt
);
  assign gnt = req & (~req + NUM_M'(1));
endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: fixed-priority, non-preemptive sharing of the rib slave bus with timeout abort
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int NUM_M = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = RIB_TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic rst,
  rib_arbiter_if.slave bus
);
  localparam int CW = rib_cnt_w(TIMEOUT);
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [NUM_M-1:0] gnt, grant, m_ack, m_err;
  logic [DATA_W-1:0] m_rdata, s_wdata, sel_wdata;
  logic [ADDR_W-1:0] s_addr, sel_addr;
  logic s_req, s_we;
  rib_prio_enc #(.NUM_M(NUM_M)) u_prio (.req(bus.m_req_i), .gnt(gnt));
  always_comb begin
    sel_addr = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_M; k++) begin
      sel_addr = sel_addr | ({ADDR_W{gnt[k]}} & bus.m_addr_i[k*ADDR_W +: ADDR_W]);
      sel_wdata = sel_wdata | ({DATA_W{gnt[k]}} & bus.m_wdata_i[k*DATA_W +: DATA_W]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RIB_IDLE;
      cnt <= '0;
      grant <= '0;
      s_req <= 1'b0;
      s_we <= 1'b0;
      s_addr <= '0;
      s_wdata <= '0;
      m_ack <= '0;
      m_err <= '0;
      m_rdata <= '0;
    end else begin
      m_ack <= '0;
      m_err <= '0;
      m_rdata <= '0;
      if (state == RIB_IDLE) begin
        if (|bus.m_req_i) begin
          state <= RIB_BUSY;
          grant <= gnt;
          s_req <= 1'b1;
          s_we <= |(gnt & bus.m_we_i);
          s_addr <= sel_addr;
          s_wdata <= sel_wdata;
          cnt <= '0;
        end
      end else if (bus.s_ack_i) begin
        state <= RIB_IDLE;
        grant <= '0;
        s_req <= 1'b0;
        m_ack <= grant;
        m_rdata <= bus.s_rdata_i;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        state <= RIB_IDLE;
        grant <= '0;
        s_req <= 1'b0;
        m_ack <= grant;
        m_err <= grant;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
  assign bus.grant_o = grant;
  assign bus.s_req_o = s_req;
  assign bus.s_we_o = s_we;
  assign bus.s_addr_o = s_addr;
  assign bus.s_wdata_o = s_wdata;
  assign bus.m_ack_o = m_ack;
  assign bus.m_err_o = m_err;
  assign bus.m_rdata_o = m_rdata;
  // the fetch master is the top index; any other requester or owner stalls the PC
  assign bus.hold_flag_o = (|bus.m_req_i[NUM_M-2:0]) | (state == RIB_BUSY && !grant[NUM_M-1]);
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(m_ack));
  a_err_with_ack: assert property (@(posedge clk) disable iff (rst) (m_err & ~m_ack) == '0);
  a_req_busy: assert property (@(posedge clk) disable iff (rst) s_req == (state == RIB_BUSY));
endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: randomized and directed checks of rib_arbiter against a transaction-level model
module tb_rib_arbiter;
  localparam int NUM_M = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [NUM_M-1:0] pending = '0;
  logic we_m [NUM_M];
  logic [ADDR_W-1:0] addr_m [NUM_M];
  logic [DATA_W-1:0] wdata_m [NUM_M];
  always #5 clk = ~clk;
  rib_arbiter_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  rib_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  function automatic logic [NUM_M-1:0] onehot(input int i);
    logic [NUM_M-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction
  function automatic int lowest(input logic [NUM_M-1:0] p);
    for (int k = 0; k < NUM_M; k++) if (p[k]) return k;
    return -1;
  endfunction
  task automatic drive();
    bus.m_req_i = pending;
    for (int k = 0; k < NUM_M; k++) begin
      bus.m_we_i[k] = we_m[k];
      bus.m_addr_i[k*ADDR_W +: ADDR_W] = addr_m[k];
      bus.m_wdata_i[k*DATA_W +: DATA_W] = wdata_m[k];
    end
  endtask
  task automatic raise(input int m);
    if (!pending[m]) begin
      pending[m] = 1'b1;
      we_m[m] = 1'($urandom);
      addr_m[m] = $urandom;
      wdata_m[m] = $urandom;
    end
    drive();
  endtask
  task automatic serve(input int d, input logic [DATA_W-1:0] rd, input int join_m, input string tag);
    int w, lat;
    logic err, exp_hold;
    @(negedge clk);
    w = lowest(pending);
    lat = (d < TIMEOUT) ? d + 1 : TIMEOUT;
    err = (d >= TIMEOUT);
    n_checks++;
    if (w < 0 || bus.grant_o !== onehot(w)) begin
      n_fail++;
      $display("FAIL %s grant: got %b want %b", tag, bus.grant_o, (w < 0) ? '0 : onehot(w));
    end
    if (w < 0) return;
    n_checks++;
    if ({bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o} !== {1'b1, we_m[w], addr_m[w], wdata_m[w]}) begin
      n_fail++;
      $display("FAIL %s slave_cmd: got req=%b we=%b a=%h d=%h want req=1 we=%b a=%h d=%h", tag,
               bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, we_m[w], addr_m[w], wdata_m[w]);
    end
    n_checks++;
    if ({bus.m_ack_o, bus.m_err_o, bus.m_rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL %s pulse_cleared: got ack=%b err=%b rdata=%h want all 0", tag, bus.m_ack_o, bus.m_err_o, bus.m_rdata_o);
    end
    for (int k = 0; k < lat; k++) begin
      exp_hold = (|pending[NUM_M-2:0]) || (w != NUM_M - 1);
      n_checks++;
      if (bus.hold_flag_o !== exp_hold) begin
        n_fail++;
        $display("FAIL %s hold_busy k=%0d: got %b want %b", tag, k, bus.hold_flag_o, exp_hold);
      end
      bus.s_ack_i = (k == d);
      bus.s_rdata_i = (k == d) ? rd : DATA_W'($urandom);
      if (k == 1 && join_m >= 0) raise(join_m);
      @(negedge clk);
      if (k + 1 < lat) begin
        n_checks++;
        if (bus.m_ack_o !== '0 || bus.grant_o !== onehot(w) || bus.s_req_o !== 1'b1 || bus.s_addr_o !== addr_m[w]) begin
          n_fail++;
          $display("FAIL %s busy_hold k=%0d: got ack=%b grant=%b sreq=%b addr=%h want ack=0 grant=%b sreq=1 addr=%h",
                   tag, k, bus.m_ack_o, bus.grant_o, bus.s_req_o, bus.s_addr_o, onehot(w), addr_m[w]);
        end
      end
    end
    bus.s_ack_i = 1'b0;
    n_checks++;
    if (bus.m_ack_o !== onehot(w) || bus.m_err_o !== (err ? onehot(w) : '0) || bus.m_rdata_o !== (err ? '0 : rd)) begin
      n_fail++;
      $display("FAIL %s completion: got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h", tag,
               bus.m_ack_o, bus.m_err_o, bus.m_rdata_o, onehot(w), err ? onehot(w) : '0, err ? '0 : rd);
    end
    n_checks++;
    if (bus.grant_o !== '0 || bus.s_req_o !== 1'b0 || bus.hold_flag_o !== (|pending[NUM_M-2:0])) begin
      n_fail++;
      $display("FAIL %s release: got grant=%b sreq=%b hold=%b want grant=0 sreq=0 hold=%b", tag,
               bus.grant_o, bus.s_req_o, bus.hold_flag_o, |pending[NUM_M-2:0]);
    end
    pending[w] = 1'b0;
    drive();
  endtask
  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.grant_o, bus.s_req_o, bus.m_ack_o, bus.m_err_o, bus.m_rdata_o} !== '0 || bus.hold_flag_o !== (|pending[NUM_M-2:0])) begin
        n_fail++;
        $display("FAIL %s idle k=%0d: got grant=%b sreq=%b ack=%b err=%b rdata=%h hold=%b want zeros hold=%b", tag, k,
                 bus.grant_o, bus.s_req_o, bus.m_ack_o, bus.m_err_o, bus.m_rdata_o, bus.hold_flag_o, |pending[NUM_M-2:0]);
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.grant_o, bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, bus.m_ack_o, bus.m_err_o, bus.m_rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got grant=%b sreq=%b we=%b addr=%h wdata=%h ack=%b err=%b want all 0",
               bus.grant_o, bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, bus.m_ack_o, bus.m_err_o);
    end
    rst = 1'b0;
    raise(1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.s_req_o !== 1'b1 || bus.grant_o !== onehot(1)) begin
      n_fail++;
      $display("FAIL reset_prebusy: got sreq=%b grant=%b want sreq=1 grant=%b", bus.s_req_o, bus.grant_o, onehot(1));
    end
    rst = 1'b1;
    pending = '0;
    drive();
    bus.s_ack_i = 1'b1;
    bus.s_rdata_i = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.grant_o, bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, bus.m_ack_o, bus.m_err_o, bus.m_rdata_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d: got grant=%b sreq=%b ack=%b err=%b rdata=%h want all 0",
                 k, bus.grant_o, bus.s_req_o, bus.m_ack_o, bus.m_err_o, bus.m_rdata_o);
      end
    end
    rst = 1'b0;
    idle(3, "reset_after");
    bus.s_ack_i = 1'b0;
  endtask
  task automatic test_priority_pair();
    raise(1);
    raise(2);
    serve(1, 32'hDEADBEEF, -1, "pair_m1");
    serve(2, DATA_W'($urandom), -1, "pair_m2");
    idle(1, "pair_idle");
  endtask
  task automatic test_no_preempt();
    raise(2);
    serve(4, DATA_W'($urandom), 0, "nopre_m2");
    serve(1, DATA_W'($urandom), -1, "nopre_m0");
    idle(1, "nopre_idle");
  endtask
  task automatic test_timeout();
    raise(2);
    we_m[2] = 1'b1;
    addr_m[2] = 32'h1000_0004;
    wdata_m[2] = 32'h55;
    drive();
    serve(1000, DATA_W'($urandom), -1, "timeout_m2");
    raise(1);
    serve(TIMEOUT - 1, DATA_W'($urandom), -1, "ack_at_last");
    idle(1, "timeout_idle");
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      raise(2);
      serve($urandom_range(0, 3), DATA_W'($urandom), -1, "b2b_fetch");
    end
    idle(2, "b2b_idle");
  endtask
  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      if (pending == '0) begin
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), "rnd_idle");
        for (int k = 0; k < NUM_M; k++) if ($urandom_range(0, 1) == 1) raise(k);
        if (pending == '0) raise($urandom_range(0, NUM_M - 1));
      end else if ($urandom_range(0, 2) == 0) begin
        raise($urandom_range(0, NUM_M - 1));
      end
      serve($urandom_range(0, 19), DATA_W'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_M - 1)) : -1, "random");
    end
    for (int k = 0; k < NUM_M; k++) if (pending != '0) serve($urandom_range(0, 5), DATA_W'($urandom), -1, "rnd_drain");
    idle(1, "rnd_end");
  endtask
  initial begin
    for (int k = 0; k < NUM_M; k++) begin
      we_m[k] = 1'b0;
      addr_m[k] = '0;
      wdata_m[k] = '0;
    end
    drive();
    bus.s_ack_i = 1'b0;
    bus.s_rdata_i = '0;
    test_reset();
    test_priority_pair();
    test_no_preempt();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Shares the single data/instruction slave bus between up to NUM_M masters using fixed-priority, non-preemptive arbitration.
- Master 0 has the highest priority (debug/jtag); master NUM_M-1 has the lowest (PC instruction fetch).
- Each grant is held for one whole slave transaction, bounded by a timeout.
- Drives hold_flag_o into ctrl's hold_flag_rib_i, so the PC stalls while the fetch master is locked out.

Parameters:
- NUM_M, 3, number of masters (2..8); index NUM_M-1 is the fetch master.
- ADDR_W, 32, address width (matches InstAddrBus).
- DATA_W, 32, data width.
- TIMEOUT, 16, cycles in BUSY without s_ack_i before abort (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m_req_i  in  NUM_M  per-master request; held high until its m_ack_o.
- m_we_i  in  NUM_M  per-master write enable.
- m_addr_i  in  NUM_M*ADDR_W  packed addresses; master k at bits [k*ADDR_W +: ADDR_W].
- m_wdata_i  in  NUM_M*DATA_W  packed write data.
- m_ack_o  out  NUM_M  one-cycle completion pulse, one-hot.
- m_err_o  out  NUM_M  one-cycle timeout pulse, coincident with m_ack_o.
- m_rdata_o  out  DATA_W  read data; valid when any m_ack_o is high.
- grant_o  out  NUM_M  one-hot current owner; 0 in IDLE.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_ack_i  in  1  slave completion; s_rdata_i is valid in the same cycle.
- s_rdata_i  in  DATA_W  slave read data.
- hold_flag_o  out  1  to ctrl hold_flag_rib_i; combinational.

Behaviour:
- Reset: state=IDLE; grant_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, m_ack_o, m_err_o, m_rdata_o, timeout counter all 0.
- Reset asserted mid-transaction abandons it: no ack, no err; s_req_o is low from the next edge.
- FSM IDLE:
  - If any m_req_i is set, latch grant = lowest set index (one-hot).
  - In the same edge, register that master's we/addr/wdata onto the s_* outputs, set s_req_o=1, clear the counter, go BUSY.
  - If no request, stay in IDLE.
- FSM BUSY:
  - s_* outputs are frozen; requests from other masters are ignored, even if higher priority (no preemption).
  - s_ack_i=1: next edge pulses m_ack_o[g]=1 and loads m_rdata_o=s_rdata_i (0 on writes is not required: pass-through); clears s_req_o and grant_o; goes IDLE.
  - Else the counter increments. When it equals TIMEOUT-1 with no ack: next edge pulses m_ack_o[g]=1 and m_err_o[g]=1, m_rdata_o=0, drops s_req_o, goes IDLE.
  - s_ack_i and the timeout in the same cycle: ack wins, m_err_o stays 0.
- Latency:
  - Request seen at edge N gives s_req_o high after N.
  - Ack at cycle M gives m_ack_o high for one cycle after M.
  - After every completion there is one IDLE cycle, so back-to-back grants are 1 cycle apart at minimum.
- If the owner drops m_req_i during BUSY, the transaction still completes and the ack pulse is still issued.
- m_ack_o, m_err_o and m_rdata_o are one-cycle registered pulses; m_rdata_o returns to 0 the following cycle.
- hold_flag_o = (any m_req_i[0..NUM_M-2]) OR (state==BUSY AND grant_o[NUM_M-1]==0).
- Starvation of the fetch master by a continuously requesting higher master is accepted by design; ctrl holds the PC meanwhile.

Decomposition:
- defines.v gets `RibIdle` / `RibBusy` state encodings, `RibTimeoutDefault` (16) and `RibMaxMasters` (8).
- hold_flag_o feeds ctrl; ctrl maps it to Hold_Pc.
- One sub-module: rib_prio_enc, a combinational lowest-index one-hot priority encoder parameterised by NUM_M.

Test Plan:
1. Reset held 3 cycles mid-BUSY, then released: all outputs 0; no m_ack_o afterwards; s_req_o low on the first post-reset cycle.
2. m_req_i=3'b110 (m1, m2) together: grant_o=3'b010 first; s_ack_i after 2 cycles with s_rdata_i=32'hDEADBEEF; m_ack_o=3'b010 with m_rdata_o=32'hDEADBEEF; then grant_o=3'b100 two cycles later.
3. m2 busy and m0 requests mid-transaction: m2 completes first, m0 is granted next; hold_flag_o=1 while m0 is requesting.
4. Write from m2 to addr 32'h1000_0004 with wdata 32'h55, slave never acks: m_ack_o[2]=m_err_o[2]=1 exactly TIMEOUT=16 cycles after s_req_o rose; m_rdata_o=0.
5. s_ack_i arrives on the cycle the counter reaches 15: m_ack_o pulses, m_err_o stays 0.
6. Only m2 requesting, idle slave: hold_flag_o=0 throughout; grant_o=3'b100; ack-to-next-grant gap is exactly 1 cycle.
